// File: rtl/card_shoe.sv
// card_shoe: single 52-card deck with in-place Fisher-Yates shuffle.
//
// A free-running 16-bit Galois LFSR supplies the swap index for each shuffle
// step. Indices that land above the current position are rejected, and the
// step retries on the next cycle. Cards are dealt from the top of the
// shuffled deck, one per accepted request. The deck reshuffles automatically
// when it runs empty, or on request while READY.
//
// Ports:
//   CLOCK_50    in   system clock, rising edge
//   reset       in   asynchronous active-high reset
//   deal_req    in   request one card (honoured only in READY)
//   shuffle_req in   force a fresh shuffle (honoured only in READY)
//   card_valid  out  one-cycle pulse, card outputs valid this cycle
//   card_value  out  blackjack value (ace = ACE_VALUE, faces = 10)
//   card_rank   out  1 = A .. 13 = K
//   card_suit   out  0-3
//   cards_left  out  cards remaining, 0-52 (0 while shuffling)
//   ready       out  high only in READY
//   shuffling   out  high in INIT or SHUFFLE
module card_shoe #(
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter int          ACE_VALUE = 1
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       deal_req,
  input  logic       shuffle_req,
  output logic       card_valid,
  output logic [3:0] card_value,
  output logic [3:0] card_rank,
  output logic [1:0] card_suit,
  output logic [5:0] cards_left,
  output logic       ready,
  output logic       shuffling
);

  // An all-zero LFSR would lock up, so a zero seed falls back to the default.
  localparam logic [15:0] SEED_EFF  = (SEED == 16'h0000) ? 16'hACE1 : SEED;
  localparam logic [3:0]  ACE_V     = 4'(ACE_VALUE);
  // Right-shift Galois form of x^16 + x^14 + x^13 + x^11 + 1.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [5:0]  LAST_IDX  = 6'd51;
  localparam logic [5:0]  DECK_SIZE = 6'd52;

  typedef enum logic [1:0] {INIT, SHUFFLE, READY} state_t;

  state_t      state;
  logic [15:0] lfsr;
  logic [5:0]  shuf_i;
  logic [5:0]  shuf_j;
  logic        swap_en;
  logic [5:0]  top_pos;
  logic [5:0]  top_card;
  logic [5:0]  deck [52];

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
  endfunction

  // Smallest all-ones mask covering i, so that masked draws are uniform over
  // a power-of-two range and rejection trims it to 0..i.
  function automatic logic [5:0] mask_of(input logic [5:0] i);
    if (i >= 6'd32)     return 6'd63;
    else if (i >= 6'd16) return 6'd31;
    else if (i >= 6'd8)  return 6'd15;
    else if (i >= 6'd4)  return 6'd7;
    else if (i >= 6'd2)  return 6'd3;
    else if (i >= 6'd1)  return 6'd1;
    else                 return 6'd0;
  endfunction

  function automatic logic [1:0] suit_of(input logic [5:0] k);
    if (k >= 6'd39)      return 2'd3;
    else if (k >= 6'd26) return 2'd2;
    else if (k >= 6'd13) return 2'd1;
    else                 return 2'd0;
  endfunction

  function automatic logic [3:0] rank_of(input logic [5:0] k);
    logic [5:0] r;
    if (k >= 6'd39)      r = k - 6'd39;
    else if (k >= 6'd26) r = k - 6'd26;
    else if (k >= 6'd13) r = k - 6'd13;
    else                 r = k;
    return 4'(r) + 4'd1;
  endfunction

  function automatic logic [3:0] value_of(input logic [3:0] rank);
    if (rank == 4'd1)       return ACE_V;
    else if (rank >= 4'd11) return 4'd10;
    else                    return rank;
  endfunction

  always_comb begin
    shuf_j   = lfsr[5:0] & mask_of(shuf_i);
    swap_en  = (state == SHUFFLE) && (shuf_j <= shuf_i);
    top_pos  = cards_left - 6'd1;
    top_card = deck[top_pos];
  end

  // Deck contents are fully rewritten in INIT, so they need no reset.
  always_ff @(posedge CLOCK_50) begin
    for (int k = 0; k < 52; k++) begin
      if (state == INIT)
        deck[k] <= 6'(k);
      else if (swap_en && (shuf_i == 6'(k)))
        deck[k] <= deck[shuf_j];
      else if (swap_en && (shuf_j == 6'(k)))
        deck[k] <= deck[shuf_i];
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state      <= INIT;
      lfsr       <= SEED_EFF;
      shuf_i     <= LAST_IDX;
      cards_left <= 6'd0;
      card_valid <= 1'b0;
      card_value <= 4'd0;
      card_rank  <= 4'd0;
      card_suit  <= 2'd0;
      ready      <= 1'b0;
      shuffling  <= 1'b1;
    end else begin
      lfsr       <= lfsr_next(lfsr);
      card_valid <= 1'b0;
      case (state)
        INIT: begin
          shuf_i <= LAST_IDX;
          state  <= SHUFFLE;
        end
        SHUFFLE: begin
          // Out-of-range draws leave i unchanged and retry next cycle.
          if (swap_en) begin
            if (shuf_i == 6'd1) begin
              state      <= READY;
              cards_left <= DECK_SIZE;
              ready      <= 1'b1;
              shuffling  <= 1'b0;
            end else begin
              shuf_i <= shuf_i - 6'd1;
            end
          end
        end
        READY: begin
          // A shuffle request takes priority over a simultaneous deal.
          if (shuffle_req) begin
            state      <= INIT;
            cards_left <= 6'd0;
            ready      <= 1'b0;
            shuffling  <= 1'b1;
          end else if (deal_req) begin
            card_valid <= 1'b1;
            card_rank  <= rank_of(top_card);
            card_suit  <= suit_of(top_card);
            card_value <= value_of(rank_of(top_card));
            cards_left <= top_pos;
            if (cards_left == 6'd1) begin
              state     <= INIT;
              ready     <= 1'b0;
              shuffling <= 1'b1;
            end
          end
        end
        default: begin
          state     <= INIT;
          ready     <= 1'b0;
          shuffling <= 1'b1;
        end
      endcase
    end
  end

endmodule
